// File: rtl/qspi_slave_if.sv
// qspi_bus: byte-level handoff between the QSPI target PHY and the downstream command handlers.
// Latency: none (wires only).
// Backpressure: none; the slave strobes cmd/data and requests read bytes, and the master answers each request with a we pulse.
// Ports (slave view): out cmd, cmd_valid, data_read, data_valid, write_done; in data_write, we.
interface qspi_bus;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic [7:0] data_read;
  logic       data_valid;
  logic       write_done;
  logic [7:0] data_write;
  logic       we;

  modport slave (
    output cmd, cmd_valid, data_read, data_valid, write_done,
    input  data_write, we
  );

  modport master (
    input  cmd, cmd_valid, data_read, data_valid, write_done,
    output data_write, we
  );
endinterface

// File: rtl/qspi_slave.sv
// qspi_slave: 4-bit QSPI target PHY, oversampling SCK/NCS/IO in the clk domain.
// Latency: strobes and read nibbles appear SYNC_STAGES+1 clk after the pad SCK edge.
// Backpressure: none; host-written bytes are strobed unconditionally, and a missing read byte underruns to 0x00.
// Ports: clk, reset (async, active high); qspi_sck/qspi_ncs/qspi_io_in pads in;
//        qspi_io_out/qspi_io_oe pads out; bus = qspi_bus.slave byte interface.
module qspi_slave #(
  parameter int SYNC_STAGES  = 2,
  parameter int DUMMY_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       qspi_sck,
  input  logic       qspi_ncs,
  input  logic [3:0] qspi_io_in,
  output logic [3:0] qspi_io_out,
  output logic       qspi_io_oe,
  qspi_bus.slave     bus
);

  localparam int DW = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
  localparam logic [DW-1:0] DUMMY_LAST = DW'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    WAIT_CS,
    IDLE,
    CMD,
    WRDATA,
    DUMMY,
    RDDATA
  } state_t;

  // ---------------------------------------------------------------------------
  // Pad synchronisers. NCS resets to 0 so that a transaction already running
  // at reset release never looks like an idle bus; WAIT_CS only exits once a
  // genuine high level has propagated through the chain.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic [3:0]             io_sync [SYNC_STAGES];
  logic                   sck_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '0;
      ncs_sync <= '0;
      sck_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        io_sync[i] <= 4'h0;
      end
    end else begin
      sck_sync[0] <= qspi_sck;
      ncs_sync[0] <= qspi_ncs;
      io_sync[0]  <= qspi_io_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i] <= sck_sync[i-1];
        ncs_sync[i] <= ncs_sync[i-1];
        io_sync[i]  <= io_sync[i-1];
      end
      sck_prev <= sck_sync[SYNC_STAGES-1];
    end
  end

  logic       sck_s;
  logic       ncs_s;
  logic [3:0] io_s;
  logic       sck_rise;
  logic       sck_fall;

  // IO goes through the same depth as SCK, so the nibble seen with the rise
  // strobe is the one the host held stable around its pad edge.
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ncs_s    = ncs_sync[SYNC_STAGES-1];
  assign io_s     = io_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t         state_q,      state_d;
  logic           nib_q,        nib_d;        // 1 = high nibble already captured
  logic [3:0]     hi_nib_q,     hi_nib_d;
  logic [DW-1:0]  dummy_q,      dummy_d;
  logic [7:0]     cmd_q,        cmd_d;
  logic           cmd_valid_q,  cmd_valid_d;
  logic [7:0]     data_read_q,  data_read_d;
  logic           data_valid_q, data_valid_d;
  logic           write_done_q, write_done_d;
  logic [7:0]     hold_q,       hold_d;
  logic           hold_full_q,  hold_full_d;
  logic [7:0]     shift_q,      shift_d;
  logic           boundary_q,   boundary_d;   // next SCK fall starts a new read byte
  logic [3:0]     io_out_q,     io_out_d;
  logic           io_oe_q,      io_oe_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_CS;
      nib_q        <= 1'b0;
      hi_nib_q     <= 4'h0;
      dummy_q      <= '0;
      cmd_q        <= 8'h00;
      cmd_valid_q  <= 1'b0;
      data_read_q  <= 8'h00;
      data_valid_q <= 1'b0;
      write_done_q <= 1'b0;
      hold_q       <= 8'h00;
      hold_full_q  <= 1'b0;
      shift_q      <= 8'h00;
      boundary_q   <= 1'b0;
      io_out_q     <= 4'h0;
      io_oe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      nib_q        <= nib_d;
      hi_nib_q     <= hi_nib_d;
      dummy_q      <= dummy_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      data_read_q  <= data_read_d;
      data_valid_q <= data_valid_d;
      write_done_q <= write_done_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      boundary_q   <= boundary_d;
      io_out_q     <= io_out_d;
      io_oe_q      <= io_oe_d;
    end
  end

  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  assign rx_byte = {hi_nib_q, io_s};
  assign tx_byte = hold_full_q ? hold_q : 8'h00;

  always_comb begin
    state_d      = state_q;
    nib_d        = nib_q;
    hi_nib_d     = hi_nib_q;
    dummy_d      = dummy_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    data_read_d  = data_read_q;
    data_valid_d = 1'b0;
    write_done_d = 1'b0;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    boundary_d   = boundary_q;
    io_out_d     = io_out_q;
    io_oe_d      = io_oe_q;

    if (ncs_s) begin
      // End of transaction or abort: drop any half byte and release the pads.
      state_d     = IDLE;
      nib_d       = 1'b0;
      io_oe_d     = 1'b0;
      hold_full_d = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_CS: ;

        IDLE: begin
          state_d = CMD;
          nib_d   = 1'b0;
        end

        CMD: begin
          if (sck_rise) begin
            if (!nib_q) begin
              hi_nib_d = io_s;
              nib_d    = 1'b1;
            end else begin
              nib_d       = 1'b0;
              cmd_d       = rx_byte;
              cmd_valid_d = 1'b1;
              if (rx_byte[7]) begin
                // Read: ask for the first byte right away so the master has
                // the dummy cycles to answer.
                write_done_d = 1'b1;
                boundary_d   = 1'b1;
                dummy_d      = '0;
                state_d      = (DUMMY_CYCLES == 0) ? RDDATA : DUMMY;
              end else begin
                state_d = WRDATA;
              end
            end
          end
        end

        WRDATA: begin
          if (sck_rise) begin
            if (!nib_q) begin
              hi_nib_d = io_s;
              nib_d    = 1'b1;
            end else begin
              nib_d        = 1'b0;
              data_read_d  = rx_byte;
              data_valid_d = 1'b1;
            end
          end
        end

        DUMMY: begin
          if (sck_rise) begin
            if (dummy_q == DUMMY_LAST) begin
              state_d = RDDATA;
            end else begin
              dummy_d = dummy_q + 1'b1;
            end
          end
        end

        RDDATA: begin
          if (sck_fall) begin
            io_oe_d = 1'b1;
            if (boundary_q) begin
              shift_d     = tx_byte;
              io_out_d    = tx_byte[7:4];
              hold_full_d = 1'b0;
              boundary_d  = 1'b0;
            end else begin
              // Low nibble goes out now; the hold register is free to refill.
              io_out_d     = shift_q[3:0];
              write_done_d = 1'b1;
              boundary_d   = 1'b1;
            end
          end
        end

        default: state_d = WAIT_CS;
      endcase
    end

    // A load wins over the boundary clear: the boundary above already took the
    // old contents, and this new byte waits for the next boundary.
    if (bus.we) begin
      hold_d      = bus.data_write;
      hold_full_d = 1'b1;
    end
  end

  assign bus.cmd        = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.data_read  = data_read_q;
  assign bus.data_valid = data_valid_q;
  assign bus.write_done = write_done_q;
  assign qspi_io_out    = io_out_q;
  assign qspi_io_oe     = io_oe_q;

endmodule
